// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, buffer entry and state types for the instruction fetch unit
package fetch_pkg;
  localparam int INST_BYTES = 4;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;
  typedef enum logic {RUN, FLUSH} fetch_state_t;
endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: circular instruction buffer with same-cycle push/pop and synchronous clear
module inst_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  entry_t        din,
  output logic [CW-1:0] count,
  output entry_t        head
);
  entry_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign do_pop = pop && count != '0 && !clear;
  assign do_push = push && !clear;
  assign head = mem[rd];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (clear) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= do_pop ? nxt(rd) : rd;
      wr <= do_push ? nxt(wr) : wr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  // a full buffer may only accept a push when the head leaves in the same cycle
  assert property (@(posedge clk) disable iff (!reset_n) push && !clear && count == CW'(DEPTH) |-> pop);
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: in-order instruction fetch with request credit limit, response buffer
// and redirect flush that discards responses of requests issued before the redirect
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(2 * DEPTH + 1);
  typedef struct packed {
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] pc;
  } entry_t;
  logic [WIDTH-1:0] fetch_pc, resp_pc, target;
  logic [CW-1:0] outstanding, fifo_count;
  logic [DW-1:0] drop_cnt, drop_next;
  fetch_state_t state, state_next;
  entry_t head;
  logic accept, rsp_ok, push, pop;
  assign target = {redirect_target[WIDTH-1:2], 2'b00};
  assign imem_req_valid = reset_n && !redirect && (DW'(outstanding) + DW'(fifo_count) < DW'(DEPTH));
  assign imem_req_addr = fetch_pc;
  assign accept = imem_req_valid && imem_req_ready;
  assign rsp_ok = imem_rsp_valid && outstanding != '0;
  assign push = rsp_ok && drop_cnt == '0 && !redirect;
  assign inst_valid = fifo_count != '0;
  assign pop = inst_valid && inst_ready;
  assign inst = inst_valid ? head.inst : '0;
  assign inst_pc = inst_valid ? head.pc : '0;
  inst_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .clear(redirect),
    .din('{inst: imem_rsp_data, pc: resp_pc}), .count(fifo_count), .head(head)
  );
  // every request still in flight at a redirect belongs to the abandoned path
  always_comb begin
    drop_next = redirect ? DW'(outstanding) - DW'(rsp_ok) : drop_cnt - DW'(rsp_ok && drop_cnt != '0);
    state_next = drop_next != '0 ? FLUSH : RUN;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
      state <= RUN;
    end else begin
      fetch_pc <= redirect ? target : accept ? fetch_pc + WIDTH'(INST_BYTES) : fetch_pc;
      resp_pc <= redirect ? target : push ? resp_pc + WIDTH'(INST_BYTES) : resp_pc;
      outstanding <= outstanding + CW'(accept) - CW'(rsp_ok);
      drop_cnt <= drop_next;
      state <= state_next;
    end
  assert property (@(posedge clk) disable iff (!reset_n) imem_rsp_valid |-> outstanding != '0);
  assert property (@(posedge clk) disable iff (!reset_n) (state == FLUSH) == (drop_cnt != '0));
endmodule
